// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus. The pipeline side (master) reports operand, LSU and
// branch status and receives per-stage controls and perf counters. The
// controller side (slave) does the reverse.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic             rs1_pending_ID;
  logic             rs2_pending_ID;
  logic             rs1_data_forwarded;
  logic             rs2_data_forwarded;
  logic             branch_taken_EX;
  logic             lsu_req_MEMEX;
  logic             lsu_ready;
  logic             perf_clear;
  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             stall_MEMPREP;
  logic             stall_MEMEX;
  logic             bubble_EX;
  logic             bubble_WB;
  logic             flush_IF;
  logic             flush_ID;
  logic             mem_fault;
  logic [CNT_W-1:0] hazard_stall_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;

  modport master (
    output rs1_used_ID, rs2_used_ID, rs1_pending_ID, rs2_pending_ID,
           rs1_data_forwarded, rs2_data_forwarded, branch_taken_EX,
           lsu_req_MEMEX, lsu_ready, perf_clear,
    input  stall_IF, stall_ID, stall_EX, stall_MEMPREP, stall_MEMEX,
           bubble_EX, bubble_WB, flush_IF, flush_ID, mem_fault,
           hazard_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  rs1_used_ID, rs2_used_ID, rs1_pending_ID, rs2_pending_ID,
           rs1_data_forwarded, rs2_data_forwarded, branch_taken_EX,
           lsu_req_MEMEX, lsu_ready, perf_clear,
    output stall_IF, stall_ID, stall_EX, stall_MEMPREP, stall_MEMEX,
           bubble_EX, bubble_WB, flush_IF, flush_ID, mem_fault,
           hazard_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage RV32E pipeline (IF ID EX MEMPREP MEMEX WB).
// Per-cycle priority: LSU fault > LSU wait > branch redirect > data hazard.
// A taken branch seen while the LSU stalls everything is remembered and
// replayed as a one-cycle redirect after the LSU releases.
module pipeline_hazard_ctrl #(
  parameter int MAX_MEM_WAIT = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT_PEND, FAULT} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_nxt;
  logic                redir_q, redir_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    haz_cnt_q, haz_cnt_d;
  logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;

  logic data_hazard, mem_wait;
  logic haz_stall, mem_stall;
  logic stall_front, stall_back, bubble_ex, bubble_wb, flush_front;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign data_hazard = (bus.rs1_used_ID & bus.rs1_pending_ID & ~bus.rs1_data_forwarded) |
                       (bus.rs2_used_ID & bus.rs2_pending_ID & ~bus.rs2_data_forwarded);
  assign mem_wait    = bus.lsu_req_MEMEX & ~bus.lsu_ready;
  assign wait_nxt    = wait_cnt_q + WAIT_W'(1);

  // Next-state and per-stage controls, highest-priority condition first.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    redir_d     = redir_q;
    fault_d     = fault_q;
    stall_front = 1'b0;
    stall_back  = 1'b0;
    bubble_ex   = 1'b0;
    bubble_wb   = 1'b0;
    flush_front = 1'b0;
    haz_stall   = 1'b0;
    mem_stall   = 1'b0;
    case (state_q)
      FAULT: begin
        stall_front = 1'b1;
        stall_back  = 1'b1;
        bubble_wb   = 1'b1;
      end
      default: begin
        if (mem_wait) begin
          // Freeze IF..MEMEX; a redirect already pending is deferred too.
          stall_front = 1'b1;
          stall_back  = 1'b1;
          bubble_wb   = 1'b1;
          mem_stall   = 1'b1;
          wait_cnt_d  = wait_nxt;
          redir_d     = redir_q | bus.branch_taken_EX | (state_q == REDIRECT_PEND);
          if (wait_nxt == WAIT_W'(MAX_MEM_WAIT)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else if (state_q == MEM_WAIT) begin
          // Release cycle: everything advances, remembered branch replays next.
          wait_cnt_d = '0;
          redir_d    = 1'b0;
          state_d    = (redir_q | bus.branch_taken_EX) ? REDIRECT_PEND : RUN;
        end else if (state_q == REDIRECT_PEND) begin
          flush_front = 1'b1;
          bubble_ex   = 1'b1;
          state_d     = RUN;
        end else if (bus.branch_taken_EX) begin
          flush_front = 1'b1;
          bubble_ex   = 1'b1;
        end else if (data_hazard) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
          haz_stall   = 1'b1;
        end
      end
    endcase
  end

  // Perf counters: clear beats increment.
  always_comb begin
    haz_cnt_d = haz_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (bus.perf_clear) begin
      haz_cnt_d = '0;
      mem_cnt_d = '0;
    end else begin
      if (haz_stall) haz_cnt_d = sat_inc(haz_cnt_q);
      if (mem_stall) mem_cnt_d = sat_inc(mem_cnt_q);
    end
  end

  // State, watchdog and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      redir_q    <= 1'b0;
      fault_q    <= 1'b0;
      haz_cnt_q  <= '0;
      mem_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      redir_q    <= redir_d;
      fault_q    <= fault_d;
      haz_cnt_q  <= haz_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
    end
  end

  // Every output reads zero while reset is asserted.
  assign bus.stall_IF         = stall_front & ~rst;
  assign bus.stall_ID         = stall_front & ~rst;
  assign bus.stall_EX         = stall_back  & ~rst;
  assign bus.stall_MEMPREP    = stall_back  & ~rst;
  assign bus.stall_MEMEX      = stall_back  & ~rst;
  assign bus.bubble_EX        = bubble_ex   & ~rst;
  assign bus.bubble_WB        = bubble_wb   & ~rst;
  assign bus.flush_IF         = flush_front & ~rst;
  assign bus.flush_ID         = flush_front & ~rst;
  assign bus.mem_fault        = fault_q     & ~rst;
  assign bus.hazard_stall_cnt = rst ? '0 : haz_cnt_q;
  assign bus.mem_stall_cnt    = rst ? '0 : mem_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a rule-level model queued and checked by a monitor.
module tb_pipeline_hazard_ctrl;
  localparam int TB_MAX = 4;
  localparam int TB_CW  = 3;
  localparam int CMAX   = (1 << TB_CW) - 1;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(TB_CW)) bus_if ();

  pipeline_hazard_ctrl #(.MAX_MEM_WAIT(TB_MAX), .CNT_W(TB_CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl order: stall IF,ID,EX,MEMPREP,MEMEX, bubble EX,WB, flush IF,ID
  typedef struct {
    logic [8:0] ctl;
    logic       fault;
    int         hc;
    int         mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // stimulus for the coming cycle
  logic s_rst, s_u1, s_u2, s_p1, s_p2, s_f1, s_f2, s_br, s_req, s_rdy, s_clr;

  // reference model state
  bit m_fault;
  int m_wait;        // consecutive LSU wait cycles so far, 0 = not waiting
  bit m_branch_seen; // taken branch observed while waiting
  bit m_redirect;    // redirect owed on the next free cycle
  int m_hc, m_mc;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (check %0d)", name, act, expv, n_cmp);
    end
  endtask

  task automatic clear_stim();
    {s_rst, s_u1, s_u2, s_p1, s_p2, s_f1, s_f2, s_br, s_req, s_rdy, s_clr} = '0;
  endtask

  task automatic model_push();
    exp_t e;
    bit   dh, mw, hinc, minc;
    e.ctl = '0; e.fault = 1'b0; e.hc = 0; e.mc = 0;
    if (s_rst) begin
      m_fault = 0; m_wait = 0; m_branch_seen = 0; m_redirect = 0; m_hc = 0; m_mc = 0;
      exp_q.push_back(e);
      return;
    end
    e.fault = m_fault; e.hc = m_hc; e.mc = m_mc;
    dh   = (s_u1 && s_p1 && !s_f1) || (s_u2 && s_p2 && !s_f2);
    mw   = s_req && !s_rdy;
    hinc = 0; minc = 0;
    if (m_fault) begin
      e.ctl = 9'b11111_01_00;
    end else if (mw) begin
      e.ctl = 9'b11111_01_00;
      minc = 1;
      m_wait++;
      m_branch_seen = m_branch_seen || s_br || m_redirect;
      m_redirect = 0;
      if (m_wait == TB_MAX) m_fault = 1;
    end else if (m_wait > 0) begin
      m_redirect = m_branch_seen || s_br;
      m_branch_seen = 0;
      m_wait = 0;
    end else if (m_redirect) begin
      e.ctl = 9'b00000_10_11;
      m_redirect = 0;
    end else if (s_br) begin
      e.ctl = 9'b00000_10_11;
    end else if (dh) begin
      e.ctl = 9'b11000_10_00;
      hinc = 1;
    end
    if (s_clr) begin
      m_hc = 0; m_mc = 0;
    end else begin
      if (hinc && m_hc < CMAX) m_hc++;
      if (minc && m_mc < CMAX) m_mc++;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    rst                       = s_rst;
    bus_if.rs1_used_ID        = s_u1;
    bus_if.rs2_used_ID        = s_u2;
    bus_if.rs1_pending_ID     = s_p1;
    bus_if.rs2_pending_ID     = s_p2;
    bus_if.rs1_data_forwarded = s_f1;
    bus_if.rs2_data_forwarded = s_f2;
    bus_if.branch_taken_EX    = s_br;
    bus_if.lsu_req_MEMEX      = s_req;
    bus_if.lsu_ready          = s_rdy;
    bus_if.perf_clear         = s_clr;
    model_push();
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", int'({bus_if.stall_IF, bus_if.stall_ID, bus_if.stall_EX,
                           bus_if.stall_MEMPREP, bus_if.stall_MEMEX,
                           bus_if.bubble_EX, bus_if.bubble_WB,
                           bus_if.flush_IF, bus_if.flush_ID}), int'(e.ctl));
        check("mem_fault", int'(bus_if.mem_fault), int'(e.fault));
        check("hazard_cnt", int'(bus_if.hazard_stall_cnt), e.hc);
        check("mem_cnt", int'(bus_if.mem_stall_cnt), e.mc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_if.rs1_used_ID = 0; bus_if.rs2_used_ID = 0;
    bus_if.rs1_pending_ID = 0; bus_if.rs2_pending_ID = 0;
    bus_if.rs1_data_forwarded = 0; bus_if.rs2_data_forwarded = 0;
    bus_if.branch_taken_EX = 0; bus_if.lsu_req_MEMEX = 0;
    bus_if.lsu_ready = 0; bus_if.perf_clear = 0;

    // reset, including a reset cycle with busy inputs
    clear_stim(); s_rst = 1; cyc(); cyc();
    s_req = 1; s_br = 1; s_u1 = 1; s_p1 = 1; cyc();
    clear_stim(); cyc();

    // data hazard on rs1 for two cycles, then forwarded case (no stall)
    s_u1 = 1; s_p1 = 1; cyc(); cyc();
    s_f1 = 1; cyc();
    clear_stim(); s_u2 = 1; s_p2 = 1; cyc();
    clear_stim(); cyc();

    // LSU wait 3 cycles then release
    s_req = 1; repeat (3) cyc();
    s_rdy = 1; cyc();
    clear_stim(); cyc();

    // taken branch during the wait: no flush until the cycle after release
    s_req = 1; cyc();
    s_br = 1; cyc();
    s_br = 0; cyc();
    s_rdy = 1; cyc();
    clear_stim(); cyc(); cyc();

    // branch and data hazard together in RUN
    s_br = 1; s_u1 = 1; s_p1 = 1; cyc();
    clear_stim(); cyc();

    // hazard counter saturation then clear
    s_clr = 1; cyc();
    clear_stim(); s_u2 = 1; s_p2 = 1; repeat (9) cyc();
    clear_stim(); cyc();
    s_clr = 1; cyc();
    clear_stim(); cyc();

    // watchdog: LSU never ready -> sticky fault until reset
    s_req = 1; repeat (6) cyc();
    s_rdy = 1; s_br = 1; cyc();
    clear_stim(); cyc();
    s_rst = 1; cyc();
    clear_stim(); cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 79) == 0);
      s_clr = ($urandom_range(0, 39) == 0);
      s_u1  = $urandom_range(0, 1); s_u2 = $urandom_range(0, 1);
      s_p1  = $urandom_range(0, 1); s_p2 = $urandom_range(0, 1);
      s_f1  = $urandom_range(0, 1); s_f2 = $urandom_range(0, 1);
      s_br  = ($urandom_range(0, 5) == 0);
      s_req = ($urandom_range(0, 9) < 6);
      s_rdy = ($urandom_range(0, 9) < 4);
      cyc();
    end
    clear_stim(); cyc();

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
